// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
// IDW is the owner-index width for the default requester count.
package arb_pkg;

   localparam int NUM_REQ_DFLT = 4;
   localparam int WGT_W_DFLT   = 4;
   localparam int IDW          = $clog2(NUM_REQ_DFLT);

   typedef enum logic {IDLE, GRANT} arb_state_t;

   // Encodes a one-hot vector of up to 16 bits; an all-zero input yields 0.
   function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (oh[i]) idx = idx | 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req bit above last_owner, wrapping.
// The search is a double-width rotate, a lowest-set-bit isolate, and an index un-rotate.
module rr_pick import arb_pkg::*; #(
   parameter  int N  = NUM_REQ_DFLT,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_owner,
   output logic [IW-1:0] winner,
   output logic          any
);

   logic [IW:0]  start;
   logic [IW:0]  sum;
   logic [N-1:0] rot;
   logic [N-1:0] low;
   logic [3:0]   offset;

   always_comb begin
      start = {1'b0, last_owner} + (IW+1)'(1);
      if (start >= (IW+1)'(N)) start = '0;
      rot    = N'({req, req} >> start);
      low    = rot & (~rot + N'(1));
      offset = onehot2idx(16'(low));
      // start and offset are both below N, so one conditional subtract wraps the sum.
      sum    = start + (IW+1)'(offset);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      winner = sum[IW-1:0];
      any    = |req;
   end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with burst ownership bounded by last, weight credit or abandon.
// Grant is registered one cycle after arbitration; exactly one idle cycle separates bursts.
module rr_burst_arbiter import arb_pkg::*; #(
   parameter  int NUM_REQ = NUM_REQ_DFLT,
   parameter  int WGT_W   = WGT_W_DFLT,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_b,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ-1:0]       last,
   input  logic [NUM_REQ*WGT_W-1:0] weight,
   input  logic                     res_rdy,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     gnt_vld,
   output logic [IW-1:0]            gnt_id,
   output logic                     beat
);

   arb_state_t       state;
   logic [WGT_W-1:0] credit;
   logic [IW-1:0]    last_owner;
   logic [IW-1:0]    winner;
   logic             any;
   logic [WGT_W-1:0] win_wgt;
   logic             owner_req;
   logic             release_now;

   rr_pick #(.N(NUM_REQ)) u_pick (
      .req        (req),
      .last_owner (last_owner),
      .winner     (winner),
      .any        (any)
   );

   assign owner_req   = req[gnt_id];
   assign beat        = gnt_vld & owner_req & res_rdy;
   assign win_wgt     = weight[winner*WGT_W +: WGT_W];
   // last and credit exhaustion in the same beat collapse into one release.
   assign release_now = !owner_req || (beat && (last[gnt_id] || credit == WGT_W'(1)));

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state      <= IDLE;
         gnt        <= '0;
         gnt_vld    <= 1'b0;
         gnt_id     <= '0;
         credit     <= '0;
         last_owner <= IW'(NUM_REQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (any) begin
                  state   <= GRANT;
                  gnt     <= NUM_REQ'(1) << winner;
                  gnt_vld <= 1'b1;
                  gnt_id  <= winner;
                  credit  <= (win_wgt == '0) ? WGT_W'(1) : win_wgt;
               end
            end
            GRANT: begin
               if (beat) credit <= credit - WGT_W'(1);
               if (release_now) begin
                  state      <= IDLE;
                  gnt        <= '0;
                  gnt_vld    <= 1'b0;
                  last_owner <= gnt_id;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
